// File: rtl/load_store_unit_if.sv
// Request/response handshake between the MEM stage and the load/store unit.
// master = pipeline side, slave = load_store_unit side.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store initiator for a word-wide DataMemory port; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests return resp_err=1 without touching memory.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    load_store_unit_if.slave      bus,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           write_data,
    input  logic [31:0]           read_data
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

    state_t      state;
    logic        ready_r;
    logic        valid_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        misaligned;

    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = valid_r;
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = err_r;

    // Size 2'b1x is a word (11 is folded into word).
    assign misaligned = TRAP_EN &&
                        (((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                         (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00)));

    function automatic logic [31:0] extend_load(input logic [31:0] data, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = off[1] ? data[31:16] : data[15:0];
        case (size)
            2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: r[{off, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Request fields are pure data; they are only consumed after an accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            off_q   <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            rdata_r    <= 32'd0;
            err_r      <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            address    <= '0;
            write_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        address <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        rdata_r <= 32'd0;
                        err_r   <= 1'b0;
                        ready_r <= 1'b0;
                        if (misaligned) begin
                            err_r   <= 1'b1;
                            valid_r <= 1'b1;
                            state   <= RESP;
                        end else if (!bus.req_write) begin
                            MemRead <= 1'b1;
                            state   <= LOAD;
                        end else if (bus.req_size[1]) begin
                            write_data <= bus.req_wdata;
                            MemWrite   <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            MemRead <= 1'b1;
                            state   <= RMW_READ;
                        end
                    end
                end
                LOAD: begin
                    rdata_r <= extend_load(read_data, size_q, off_q, uns_q);
                    MemRead <= 1'b0;
                    valid_r <= 1'b1;
                    state   <= RESP;
                end
                RMW_READ: begin
                    write_data <= merge_store(read_data, wdata_q, size_q, off_q);
                    MemRead    <= 1'b0;
                    MemWrite   <= 1'b1;
                    state      <= WRITE;
                end
                WRITE: begin
                    MemWrite <= 1'b0;
                    valid_r  <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    valid_r  <= 1'b0;
                    ready_r  <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-addressed memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] address, write_data, read_data;

    int total = 0;
    int bad   = 0;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_wdata = 32'd0;
    logic        unused_addr_bits;

    assign read_data        = mem[address[5:2]];
    assign unused_addr_bits = ^{address[31:6], address[1:0]};

    always @(posedge clk) begin
        if (MemWrite) begin
            mem[address[5:2]] <= write_data;
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= address;
            last_wdata <= write_data;
        end
        if (MemRead) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request, return cycle count from the accept cycle (=0) to resp_valid.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
    endtask

    task automatic complete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          w0, r0;
        logic [31:0] held;

        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.resp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mem_ctl", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_rdata_err", {bus.resp_rdata[30:0], bus.resp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Word store then word load at 0x4
        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h11111111, lat, rd, er);
        chk("wst_latency", 32'(lat), 32'd2);
        chk("wst_write_cycles", 32'(wr_cnt - w0), 32'd1);
        chk("wst_write_addr", last_waddr, 32'h4);
        chk("wst_rdata_zero", rd, 32'd0);
        complete();
        chk("wst_ready_back", {31'd0, bus.req_ready}, 32'd1);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'd0, lat, rd, er);
        chk("wld_latency", 32'(lat), 32'd2);
        chk("wld_rdata", rd, 32'h11111111);
        chk("wld_err", {31'd0, er}, 32'd0);
        complete();

        // Sub-word store by read-modify-write
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h22222222, lat, rd, er);
        complete();
        w0 = wr_cnt;
        r0 = rd_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'hA, 32'h000000AB, lat, rd, er);
        chk("bst_latency", 32'(lat), 32'd3);
        chk("bst_read_cycles", 32'(rd_cnt - r0), 32'd1);
        chk("bst_write_cycles", 32'(wr_cnt - w0), 32'd1);
        chk("bst_write_data", last_wdata, 32'h22AB2222);
        chk("bst_write_addr", last_waddr, 32'h8);
        complete();
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, lat, rd, er);
        chk("bst_readback", rd, 32'h22AB2222);
        complete();

        // Load extension on 0x80FF7F01
        issue(1'b1, 2'b10, 1'b0, 32'hC, 32'h80FF7F01, lat, rd, er);
        complete();
        issue(1'b0, 2'b00, 1'b0, 32'hE, 32'd0, lat, rd, er);
        chk("lb_signed_e", rd, 32'hFFFFFFFF);
        complete();
        issue(1'b0, 2'b00, 1'b1, 32'hE, 32'd0, lat, rd, er);
        chk("lb_unsigned_e", rd, 32'h000000FF);
        complete();
        issue(1'b0, 2'b00, 1'b0, 32'hD, 32'd0, lat, rd, er);
        chk("lb_signed_d", rd, 32'h0000007F);
        complete();
        issue(1'b0, 2'b00, 1'b0, 32'hF, 32'd0, lat, rd, er);
        chk("lb_signed_f", rd, 32'hFFFFFF80);
        complete();
        issue(1'b0, 2'b01, 1'b0, 32'hC, 32'd0, lat, rd, er);
        chk("lh_signed_c", rd, 32'h00007F01);
        complete();
        issue(1'b0, 2'b01, 1'b0, 32'hE, 32'd0, lat, rd, er);
        chk("lh_signed_e", rd, 32'hFFFF80FF);
        complete();
        issue(1'b0, 2'b01, 1'b1, 32'hE, 32'd0, lat, rd, er);
        chk("lh_unsigned_e", rd, 32'h000080FF);
        complete();

        // Response backpressure
        bus.resp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'hC, 32'd0, lat, rd, er);
        held = rd;
        chk("bp_rdata", held, 32'h80FF7F01);
        w0 = wr_cnt;
        r0 = rd_cnt;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid_held", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_rdata_held", bus.resp_rdata, held);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        chk("bp_no_mem_access", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
        bus.resp_ready = 1'b1;
        complete();
        chk("bp_ready_back", {31'd0, bus.req_ready}, 32'd1);
        chk("bp_valid_drop", {31'd0, bus.resp_valid}, 32'd0);

        // Misaligned half store to 0x5
        w0 = wr_cnt;
        issue(1'b1, 2'b01, 1'b0, 32'h5, 32'h0000BEEF, lat, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_latency", 32'(lat), 32'd1);
        chk("mis_err", {31'd0, er}, 32'd1);
        chk("mis_rdata", rd, 32'd0);
        chk("mis_no_write", 32'(wr_cnt - w0), 32'd0);
        complete();
        chk("mis_mem_kept", mem[1], 32'h11111111);
`else
        chk("mis_latency", 32'(lat), 32'd3);
        chk("mis_err", {31'd0, er}, 32'd0);
        chk("mis_one_write", 32'(wr_cnt - w0), 32'd1);
        complete();
        chk("mis_mem_merged", mem[1], 32'h1111BEEF);
`endif

        // Reset while in RMW_READ drops the store
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h33333333, lat, rd, er);
        complete();
        w0 = wr_cnt;
        @(negedge clk);
        bus.req_write    = 1'b1;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h11;
        bus.req_wdata    = 32'h00000055;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("rmw_in_read", {30'd0, MemRead, MemWrite}, 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rmwrst_mem_ctl", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("rmwrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rmwrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("rmwrst_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("rmwrst_mem_kept", mem[4], 32'h33333333);
        chk("rmwrst_no_resp", {31'd0, bus.resp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
